rf_wb_arbiter: RTL and testbench
================================

# rf_wb_arbiter

Write-back arbiter for the 32 x 32-bit register bank. Shares the bank's single write port between two requesters, port 0 (ALU result) and port 1 (load result), using round-robin arbitration and a registered write stage. Writes to x0 are consumed but never issued. Also provides read bypass for the write pending in the stage and a saturating conflict counter.

## Interface
- XLEN, 32, data width
- AW, 5, register address width
- CNTW, 16, conflict counter width
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset; asynchronous, active-high
- req0_valid  in  1  port 0 has a write-back pending
- req0_ready  out  1  port 0 request consumed this cycle
- req0_addr  in  AW  port 0 destination register
- req0_data  in  XLEN  port 0 write data
- req1_valid / req1_ready / req1_addr / req1_data  same as port 0, for port 1
- br_we  out  1  bank write enable (registered)
- br_a3  out  AW  bank write address (registered)
- br_wd3  out  XLEN  bank write data (registered)
- ra1, ra2  in  AW  read addresses also driven to the bank
- br_rd1, br_rd2  in  XLEN  raw bank read data
- rd1, rd2  out  XLEN  bypassed read data
- conflict_cnt  out  CNTW  cycles with both requests valid, saturating

## Operation
- Handshake: a transfer on port i occurs in a cycle where reqi_valid=1 and reqi_ready=1. Once reqi_valid is raised, the requester holds it, addr and data stable until that transfer.
- readyi is combinational from the valids and the pointer. At most one ready is high per cycle. Ready never depends on the bank, because the stage accepts one write every cycle.
- Grant rule:
  - Exactly one valid: that port is granted.
  - Both valid: grant the port that differs from last_grant.
  - Neither valid: no grant.
- last_grant (1 bit) updates to the granted port on every grant. It holds when there is no grant.
- Write stage, on each posedge:
  - With a grant: br_we <= (granted addr != 0), br_a3 <= addr, br_wd3 <= data.
  - Without a grant: br_we <= 0, and br_a3/br_wd3 hold their values.
- An x0 request is arbitrated and acknowledged normally, updates last_grant, and produces br_we=0.
- Bypass:
  - rd1 = br_wd3 when br_we=1 and ra1==br_a3 (br_a3 != 0 is implied by br_we); otherwise rd1 = br_rd1.
  - rd2 uses the same rule with ra2 and br_rd2.
- conflict_cnt increments by 1 on each posedge where req0_valid & req1_valid, and stops at 2^CNTW-1.

## Timing
- Reset values: br_we=0, br_a3=0, br_wd3=0, last_grant=1 (port 0 wins the first contention), conflict_cnt=0.
- While rst=1, req0_ready=req1_ready=0. No transfer occurs, and br_we is forced to 0 asynchronously.
- If rst asserts while a request is pending, that request is not consumed. After reset the requester still holds it, and it is re-arbitrated from the reset pointer.
- Latency: a transfer in cycle N gives br_we/br_a3/br_wd3 valid during cycle N+1. The bank writes at the posedge ending cycle N+1.
- Read results:
  - Bypassed read: correct data during cycle N+1.
  - Unbypassed read of the same register: correct from cycle N+2.
- Throughput: one write per cycle. Under continuous contention the grants alternate 0,1,0,1,… with no bubbles.
- Worst-case wait for a valid requester is 1 cycle.
- Back-to-back writes to the same register: the later transfer overwrites the stage, and bypass returns the newest value.

## Test plan
- Reset, then req0 valid only (addr=5, data=0xDEADBEEF) → req0_ready=1 in the same cycle; next cycle br_we=1, br_a3=5, br_wd3=0xDEADBEEF; rd1 with ra1=5 returns 0xDEADBEEF before the bank updates.
- Both valid for 4 cycles straight from reset, each requester presenting a new request after every transfer (port 0 addr 1/2, port 1 addr 3/4) → grant order 0,1,0,1; stage address sequence 1,3,2,4; conflict_cnt=4.
- req1 valid with addr=0, data=0x12345678 → req1_ready=1; next cycle br_we=0; a subsequent contention grants port 0.
- Both valid, rst asserted mid-cycle before the edge → br_we=0 immediately and no ready. After release, port 0 is granted first and port 1 the next cycle.
- Hold both valid for 2^CNTW+5 cycles (use CNTW=4: 21 cycles) → conflict_cnt saturates at 15 and stays there.
- ra2 equals br_a3 with br_we=0 → rd2=br_rd2 (no bypass).

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter for the 32 x 32-bit register bank.
// Round-robin shares the single bank write port between ALU and load.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   req0_*             port 0 (ALU result) valid/ready/addr/data
//   req1_*             port 1 (load result) valid/ready/addr/data
//   br_we/br_a3/br_wd3 registered bank write port
//   ra1, ra2           bank read addresses (for bypass compare)
//   br_rd1, br_rd2     raw bank read data
//   rd1, rd2           read data with write-stage bypass
//   conflict_cnt       saturating count of cycles with both valid
module rf_wb_arbiter #(
    parameter int XLEN = 32,
    parameter int AW   = 5,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [AW-1:0]   req0_addr,
    input  logic [XLEN-1:0] req0_data,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [AW-1:0]   req1_addr,
    input  logic [XLEN-1:0] req1_data,
    output logic            br_we,
    output logic [AW-1:0]   br_a3,
    output logic [XLEN-1:0] br_wd3,
    input  logic [AW-1:0]   ra1,
    input  logic [AW-1:0]   ra2,
    input  logic [XLEN-1:0] br_rd1,
    input  logic [XLEN-1:0] br_rd2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    output logic [CNTW-1:0] conflict_cnt
);

    // Port that won the most recent grant; reset to 1 so port 0
    // wins the first contention.
    logic            last_grant;
    logic            gnt0;
    logic            gnt1;
    logic            gnt;
    logic [AW-1:0]   sel_addr;
    logic [XLEN-1:0] sel_data;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        // Nothing is consumed while reset is held, so a pending
        // request survives reset and is re-arbitrated afterwards.
        if (!rst) begin
            unique case ({req1_valid, req0_valid})
                2'b01: gnt0 = 1'b1;
                2'b10: gnt1 = 1'b1;
                2'b11: begin
                    if (last_grant) gnt0 = 1'b1;
                    else            gnt1 = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign gnt        = gnt0 | gnt1;
    assign sel_addr   = gnt1 ? req1_addr : req0_addr;
    assign sel_data   = gnt1 ? req1_data : req0_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (gnt) begin
            last_grant <= gnt1;
        end
    end

    // Write stage. An x0 write is consumed but never reaches the bank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_we  <= 1'b0;
            br_a3  <= '0;
            br_wd3 <= '0;
        end else begin
            br_we <= gnt && (sel_addr != '0);
            if (gnt) begin
                br_a3  <= sel_addr;
                br_wd3 <= sel_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_cnt <= '0;
        end else if (req0_valid && req1_valid
                     && (conflict_cnt != '1)) begin
            conflict_cnt <= conflict_cnt + 1'b1;
        end
    end

    // br_we already excludes x0, so no separate zero check here.
    assign rd1 = (br_we && (ra1 == br_a3)) ? br_wd3 : br_rd1;
    assign rd2 = (br_we && (ra2 == br_a3)) ? br_wd3 : br_rd2;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Testbench for rf_wb_arbiter: vector table plus
// hand-written reset and counter-saturation sequences.
module tb_rf_wb_arbiter;

    localparam logic [31:0] B1 = 32'hAAAA_0001;
    localparam logic [31:0] B2 = 32'hBBBB_0002;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        v0 = 1'b0;
    logic        v1 = 1'b0;
    logic        rdy0, rdy1;
    logic [4:0]  a0 = '0, a1 = '0;
    logic [31:0] d0 = '0, d1 = '0;
    logic        we;
    logic [4:0]  a3;
    logic [31:0] wd3;
    logic [4:0]  ra1 = '0, ra2 = '0;
    logic [31:0] brd1 = B1, brd2 = B2;
    logic [31:0] rd1, rd2;
    logic [3:0]  cnt;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rf_wb_arbiter #(.XLEN(32), .AW(5), .CNTW(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(v0), .req0_ready(rdy0),
        .req0_addr(a0), .req0_data(d0),
        .req1_valid(v1), .req1_ready(rdy1),
        .req1_addr(a1), .req1_data(d1),
        .br_we(we), .br_a3(a3), .br_wd3(wd3),
        .ra1(ra1), .ra2(ra2),
        .br_rd1(brd1), .br_rd2(brd2),
        .rd1(rd1), .rd2(rd2),
        .conflict_cnt(cnt)
    );

    typedef struct {
        logic        rst;
        logic        v0;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic        v1;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic        e_rdy0;
        logic        e_rdy1;
        logic        e_we;
        logic [4:0]  e_a3;
        logic [31:0] e_wd3;
        logic [3:0]  e_cnt;
        logic [31:0] e_rd1;
        logic [31:0] e_rd2;
    } vec_t;

    vec_t tv[13];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    initial begin
        // Expected outputs are sampled before the edge closing each
        // row, so registered fields reflect the previous row's grant.
        tv[0]  = '{1,1,1,32'h11,1,3,32'h33,5,0,
                   0,0,0,0,0,0,B1,B2};
        tv[1]  = '{0,1,5,32'hDEADBEEF,0,0,0,5,0,
                   1,0,0,0,0,0,B1,B2};
        tv[2]  = '{0,0,0,0,0,0,0,5,3,
                   0,0,1,5,32'hDEADBEEF,0,32'hDEADBEEF,B2};
        tv[3]  = '{0,0,0,0,0,0,0,5,5,
                   0,0,0,5,32'hDEADBEEF,0,B1,B2};
        tv[4]  = '{1,1,1,32'h11,1,3,32'h33,0,0,
                   0,0,0,0,0,0,B1,B2};
        tv[5]  = '{0,1,1,32'h11,1,3,32'h33,1,3,
                   1,0,0,0,0,0,B1,B2};
        tv[6]  = '{0,1,2,32'h22,1,3,32'h33,1,3,
                   0,1,1,1,32'h11,1,32'h11,B2};
        tv[7]  = '{0,1,2,32'h22,1,4,32'h44,1,3,
                   1,0,1,3,32'h33,2,B1,32'h33};
        tv[8]  = '{0,1,7,32'h77,1,4,32'h44,2,9,
                   0,1,1,2,32'h22,3,32'h22,B2};
        tv[9]  = '{0,1,7,32'h77,0,0,0,4,4,
                   1,0,1,4,32'h44,4,32'h44,32'h44};
        tv[10] = '{0,0,0,0,1,0,32'h12345678,7,0,
                   0,1,1,7,32'h77,4,32'h77,B2};
        tv[11] = '{0,1,8,32'h88,1,9,32'h99,0,8,
                   1,0,0,0,32'h12345678,4,B1,B2};
        tv[12] = '{0,1,10,32'h100,1,9,32'h99,8,9,
                   0,1,1,8,32'h88,5,32'h88,B2};

        @(posedge clk);
        #1;
        for (int i = 0; i < 13; i++) begin
            rst = tv[i].rst;
            v0  = tv[i].v0;
            a0  = tv[i].a0;
            d0  = tv[i].d0;
            v1  = tv[i].v1;
            a1  = tv[i].a1;
            d1  = tv[i].d1;
            ra1 = tv[i].ra1;
            ra2 = tv[i].ra2;
            #3;
            chk($sformatf("v%0d rdy0", i), 32'(rdy0), 32'(tv[i].e_rdy0));
            chk($sformatf("v%0d rdy1", i), 32'(rdy1), 32'(tv[i].e_rdy1));
            chk($sformatf("v%0d we", i), 32'(we), 32'(tv[i].e_we));
            chk($sformatf("v%0d a3", i), 32'(a3), 32'(tv[i].e_a3));
            chk($sformatf("v%0d wd3", i), wd3, tv[i].e_wd3);
            chk($sformatf("v%0d cnt", i), 32'(cnt), 32'(tv[i].e_cnt));
            chk($sformatf("v%0d rd1", i), rd1, tv[i].e_rd1);
            chk($sformatf("v%0d rd2", i), rd2, tv[i].e_rd2);
            @(posedge clk);
            #1;
        end

        // Reset raised mid-cycle with both requests pending.
        // Stage holds 9/0x99, last grant was port 1.
        v0 = 1; a0 = 10; d0 = 32'h100;
        v1 = 1; a1 = 11; d1 = 32'h111;
        ra1 = 9;
        #1;
        chk("pre-rst rdy0", 32'(rdy0), 32'd1);
        chk("pre-rst we", 32'(we), 32'd1);
        chk("pre-rst rd1", rd1, 32'h99);
        #1 rst = 1;
        #1;
        chk("rst we", 32'(we), 32'd0);
        chk("rst rdy0", 32'(rdy0), 32'd0);
        chk("rst rdy1", 32'(rdy1), 32'd0);
        chk("rst rd1", rd1, B1);
        chk("rst cnt", 32'(cnt), 32'd0);
        @(posedge clk);
        #1 rst = 0;
        #2;
        chk("post-rst rdy0", 32'(rdy0), 32'd1);
        chk("post-rst rdy1", 32'(rdy1), 32'd0);
        @(posedge clk);
        #1 a0 = 12; d0 = 32'h120;
        #2;
        chk("post-rst2 rdy0", 32'(rdy0), 32'd0);
        chk("post-rst2 rdy1", 32'(rdy1), 32'd1);
        chk("post-rst2 a3", 32'(a3), 32'd10);
        chk("post-rst2 wd3", wd3, 32'h100);
        @(posedge clk);
        #1;
        chk("post-rst3 we", 32'(we), 32'd1);
        chk("post-rst3 a3", 32'(a3), 32'd11);
        chk("post-rst3 wd3", wd3, 32'h111);
        chk("post-rst3 cnt", 32'(cnt), 32'd2);

        // Counter saturation over 21 contended cycles.
        rst = 1;
        #2 rst = 0;
        chk("sat start", 32'(cnt), 32'd0);
        repeat (14) @(posedge clk);
        #1 chk("sat 14", 32'(cnt), 32'd14);
        @(posedge clk);
        #1 chk("sat 15", 32'(cnt), 32'd15);
        repeat (6) @(posedge clk);
        #1 chk("sat 21", 32'(cnt), 32'd15);
        v0 = 0;
        v1 = 0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
